// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for core0.
// Fetches via AR/IR, decodes opcodes, drives datapath strobes.
module control_unit #(
  parameter int OPW  = 8,
  parameter int SELW = 5
) (
  input  logic            clock,
  input  logic            RST,
  input  logic            start,
  input  logic [OPW-1:0]  ir,
  input  logic            z,
  output logic [SELW-1:0] bus_sel,
  output logic [9:0]      ld,
  output logic [4:0]      inc,
  output logic [6:0]      rst,
  output logic [2:0]      alu_op,
  output logic            write_en,
  output logic            done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_F1, S_F2, S_F3,
    S_EX, S_EX2, S_J2, S_J3, S_HALT
  } state_t;

  localparam logic [SELW-1:0] B_DM = SELW'(1);
  localparam logic [SELW-1:0] B_IM = SELW'(2);
  localparam logic [SELW-1:0] B_PC = SELW'(4);
  localparam logic [SELW-1:0] B_R  = SELW'(6);
  localparam logic [SELW-1:0] B_AC = SELW'(7);

  localparam int L_AC  = 0;
  localparam int L_AR  = 1;
  localparam int L_DAR = 2;
  localparam int L_IR  = 3;
  localparam int L_PC  = 4;
  localparam int L_TAC = 5;
  localparam int L_R   = 6;
  localparam int L_CI  = 7;
  localparam int L_CJ  = 8;
  localparam int L_CK  = 9;

  localparam int I_DAR = 0;
  localparam int I_PC  = 1;
  localparam int I_SI  = 2;
  localparam int I_SJ  = 3;
  localparam int I_SK  = 4;

  localparam int R_AC  = 0;
  localparam int R_DAR = 1;
  localparam int R_TAC = 3;
  localparam int R_SI  = 4;
  localparam int R_SJ  = 5;
  localparam int R_SK  = 6;

  localparam logic [2:0] A_PASS = 3'd0;
  localparam logic [2:0] A_INC  = 3'd4;

  state_t     state_q, state_d;
  logic [3:0] hi, lo;
  logic       taken;

  assign hi = ir[OPW-1 -: 4];
  assign lo = ir[3:0];

  // Branch condition from low opcode bits and the AC zero flag
  always_comb begin
    taken = 1'b0;
    unique case (lo)
      4'h0:    taken = 1'b1;
      4'h1:    taken = ~z;
      4'h2:    taken = z;
      default: taken = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clock) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state strobe decode
  always_comb begin
    state_d  = state_q;
    bus_sel  = '0;
    ld       = '0;
    inc      = '0;
    rst      = '0;
    alu_op   = A_PASS;
    write_en = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR: begin
        rst     = '1;
        state_d = S_F1;
      end
      S_F1: begin
        bus_sel   = B_PC;
        ld[L_AR]  = 1'b1;
        state_d   = S_F2;
      end
      S_F2: state_d = S_F3;
      S_F3: begin
        bus_sel   = B_IM;
        ld[L_IR]  = 1'b1;
        inc[I_PC] = 1'b1;
        state_d   = S_EX;
      end
      S_EX: begin
        state_d = S_F1;
        unique case (1'b1)
          (hi == 4'h0 && lo == 4'h1): state_d = S_EX2;
          (hi == 4'h0 && lo == 4'h2): begin
            bus_sel  = B_AC;
            write_en = 1'b1;
          end
          (hi == 4'h1 && lo <= 4'h5): begin
            bus_sel = B_AC;
            unique case (lo)
              4'h0:    ld[L_TAC] = 1'b1;
              4'h1:    ld[L_R]   = 1'b1;
              4'h2:    ld[L_CI]  = 1'b1;
              4'h3:    ld[L_CJ]  = 1'b1;
              4'h4:    ld[L_CK]  = 1'b1;
              default: ld[L_DAR] = 1'b1;
            endcase
          end
          (hi == 4'h2 && lo <= 4'hB): begin
            bus_sel  = SELW'(lo) + SELW'(5);
            ld[L_AC] = 1'b1;
          end
          (hi == 4'h3 && lo <= 4'h2): begin
            bus_sel  = B_R;
            alu_op   = lo[2:0] + 3'd1;
            ld[L_AC] = 1'b1;
          end
          (hi == 4'h4 && lo <= 4'h4): begin
            unique case (lo)
              4'h0: inc[I_SI]  = 1'b1;
              4'h1: inc[I_SJ]  = 1'b1;
              4'h2: inc[I_SK]  = 1'b1;
              4'h3: inc[I_DAR] = 1'b1;
              default: begin
                alu_op   = A_INC;
                ld[L_AC] = 1'b1;
              end
            endcase
          end
          (hi == 4'h5 && lo <= 4'h5): begin
            unique case (lo)
              4'h0:    rst[R_SI]  = 1'b1;
              4'h1:    rst[R_SJ]  = 1'b1;
              4'h2:    rst[R_SK]  = 1'b1;
              4'h3:    rst[R_DAR] = 1'b1;
              4'h4:    rst[R_AC]  = 1'b1;
              default: rst[R_TAC] = 1'b1;
            endcase
          end
          (hi == 4'h6 && lo <= 4'h2): begin
            bus_sel  = B_PC;
            ld[L_AR] = 1'b1;
            state_d  = S_J2;
          end
          (hi == 4'hF && lo == 4'hF): state_d = S_HALT;
          default: ;
        endcase
      end
      S_EX2: begin
        bus_sel  = B_DM;
        alu_op   = A_PASS;
        ld[L_AC] = 1'b1;
        state_d  = S_F1;
      end
      S_J2: state_d = S_J3;
      S_J3: begin
        if (taken) begin
          bus_sel  = B_IM;
          ld[L_PC] = 1'b1;
        end else begin
          inc[I_PC] = 1'b1;
        end
        state_d = S_F1;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) state_d = S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors for control_unit.
// Expected strobes are queued per cycle and checked by a monitor.
module tb_control_unit;

  logic       clock;
  logic       RST;
  logic       start;
  logic [7:0] ir;
  logic       z;
  logic [4:0] bus_sel;
  logic [9:0] ld;
  logic [4:0] inc;
  logic [6:0] rst;
  logic [2:0] alu_op;
  logic       write_en;
  logic       done;

  typedef struct {
    logic [31:0] v;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_vec;
  int    n_err;

  control_unit #(.OPW(8), .SELW(5)) dut (
    .clock(clock), .RST(RST), .start(start),
    .ir(ir), .z(z), .bus_sel(bus_sel), .ld(ld),
    .inc(inc), .rst(rst), .alu_op(alu_op),
    .write_en(write_en), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // packing: {bus_sel, ld, inc, rst, alu_op, write_en, done}
  function automatic logic [31:0] e(
    input int b, input int l, input int i,
    input int r, input int a, input int w,
    input int d);
    logic [31:0] t;
    t = {b[4:0], l[9:0], i[4:0], r[6:0],
         a[2:0], w[0], d[0]};
    return t;
  endfunction

  task automatic step(input logic r, input logic s,
                      input logic [7:0] i, input logic zz,
                      input logic [31:0] ex,
                      input string tag);
    item_t it;
    @(posedge clock);
    #1;
    RST   = r;
    start = s;
    ir    = i;
    z     = zz;
    it.v   = ex;
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic fetch(input logic [7:0] i, input logic zz);
    step(0, 0, i, zz, e(4, 'h002, 0, 0, 0, 0, 0), "F1");
    step(0, 0, i, zz, e(0, 0, 0, 0, 0, 0, 0), "F2");
    step(0, 0, i, zz, e(2, 'h008, 'h02, 0, 0, 0, 0), "F3");
  endtask

  // Monitor: compare DUT strobes against queued expectation
  always @(negedge clock) begin
    item_t       it;
    logic [31:0] act;
    if (sb.size() != 0) begin
      it  = sb.pop_front();
      act = {bus_sel, ld, inc, rst, alu_op, write_en, done};
      n_vec++;
      if (act !== it.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h", it.tag, act, it.v);
      end
    end
  end

  localparam logic [31:0] ZERO = 32'h0;

  initial begin
    n_vec = 0;
    n_err = 0;
    RST   = 1'b1;
    start = 1'b0;
    ir    = 8'h00;
    z     = 1'b0;
    repeat (2) @(posedge clock);

    step(0, 0, 8'h00, 0, ZERO, "reset idle");
    step(0, 0, 8'h00, 0, ZERO, "idle held");
    step(0, 1, 8'h00, 0, ZERO, "idle start");
    step(0, 0, 8'h00, 0, e(0, 0, 0, 'h7F, 0, 0, 0), "CLR");

    fetch(8'h00, 0);
    step(0, 0, 8'h00, 0, ZERO, "EX NOP");

    fetch(8'h01, 0);
    step(0, 0, 8'h01, 0, ZERO, "EX LDAC wait");
    step(0, 0, 8'h01, 0, e(1, 'h001, 0, 0, 0, 0, 0), "EX2 LDAC");

    fetch(8'h02, 0);
    step(0, 0, 8'h02, 0, e(7, 0, 0, 0, 0, 1, 0), "EX STAC");

    fetch(8'h61, 0);
    step(0, 0, 8'h61, 0, e(4, 'h002, 0, 0, 0, 0, 0), "J1 JMPNZ");
    step(0, 0, 8'h61, 0, ZERO, "J2 JMPNZ");
    step(0, 0, 8'h61, 0, e(2, 'h010, 0, 0, 0, 0, 0), "J3 JMPNZ taken");

    fetch(8'h61, 1);
    step(0, 0, 8'h61, 1, e(4, 'h002, 0, 0, 0, 0, 0), "J1 JMPNZ z");
    step(0, 1, 8'h61, 1, ZERO, "J2 start ignored");
    step(0, 0, 8'h61, 1, e(0, 0, 'h02, 0, 0, 0, 0), "J3 JMPNZ skip");

    fetch(8'h62, 1);
    step(0, 0, 8'h62, 1, e(4, 'h002, 0, 0, 0, 0, 0), "J1 JMPZ");
    step(0, 0, 8'h62, 1, ZERO, "J2 JMPZ");
    step(0, 0, 8'h62, 1, e(2, 'h010, 0, 0, 0, 0, 0), "J3 JMPZ taken");

    fetch(8'h25, 0);
    step(0, 0, 8'h25, 0, e(10, 'h001, 0, 0, 0, 0, 0), "EX MOV CI");
    fetch(8'h2C, 0);
    step(0, 0, 8'h2C, 0, ZERO, "EX MOV s12");
    fetch(8'h44, 0);
    step(0, 0, 8'h44, 0, e(0, 'h001, 0, 0, 4, 0, 0), "EX INC AC");
    fetch(8'h40, 0);
    step(0, 0, 8'h40, 0, e(0, 0, 'h04, 0, 0, 0, 0), "EX INC SI");
    fetch(8'h52, 0);
    step(0, 0, 8'h52, 0, e(0, 0, 0, 'h40, 0, 0, 0), "EX CLR SK");
    fetch(8'h32, 0);
    step(0, 0, 8'h32, 0, e(6, 'h001, 0, 0, 3, 0, 0), "EX MUL");
    fetch(8'h13, 0);
    step(0, 0, 8'h13, 0, e(7, 'h100, 0, 0, 0, 0, 0), "EX MVAC CJ");

    fetch(8'hFF, 0);
    step(0, 0, 8'hFF, 0, ZERO, "EX END");
    step(0, 0, 8'hFF, 0, e(0, 0, 0, 0, 0, 0, 1), "HALT 1");
    step(0, 0, 8'hFF, 0, e(0, 0, 0, 0, 0, 0, 1), "HALT 2");
    step(0, 1, 8'hFF, 0, e(0, 0, 0, 0, 0, 0, 1), "HALT start");
    step(0, 0, 8'h60, 0, e(0, 0, 0, 'h7F, 0, 0, 0), "CLR from HALT");

    fetch(8'h60, 0);
    step(0, 0, 8'h60, 0, e(4, 'h002, 0, 0, 0, 0, 0), "J1 JMP");
    step(1, 0, 8'h60, 0, ZERO, "J2 with RST");
    step(0, 0, 8'h60, 0, ZERO, "after RST idle");
    step(0, 0, 8'h60, 0, ZERO, "idle stays");

    repeat (2) @(posedge clock);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
